// File: rtl/child_fanin_collector.sv
// Collects one-word messages from N_CHILD children via round-robin req/ack,
// buffers {index, payload} in a small FIFO and streams them upstream.
module child_fanin_collector #(
    parameter  int N_CHILD    = 15,
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(N_CHILD),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CHILD-1:0]          child_req,
    input  logic [N_CHILD*DATA_W-1:0]   child_data,
    output logic [N_CHILD-1:0]          child_ack,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic [CNT_W-1:0]            fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [FIFO_DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [IDX_W-1:0]        last_grant_q;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic                    push, pop;

    // Search from last_grant+1 upward, wrapping modulo N_CHILD so unused
    // index codes are never produced.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N_CHILD; k++) begin
            cand = IDX_W'((32'(last_grant_q) + 32'(k)) % 32'(N_CHILD));
            if (!grant_vld && child_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // No pass-through: a full FIFO blocks grants even if a pop happens this cycle.
    always_comb begin
        child_ack = '0;
        if (rst_n && grant_vld && (count_q < CNT_W'(FIFO_DEPTH)))
            child_ack[grant_idx] = 1'b1;
    end

    assign push      = |child_ack;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_idx   = mem_q[rd_ptr_q].idx;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= IDX_W'(N_CHILD - 1);
        end else begin
            if (push) begin
                mem_q[wr_ptr_q].idx  <= grant_idx;
                mem_q[wr_ptr_q].data <= child_data[grant_idx*DATA_W +: DATA_W];
                wr_ptr_q             <= wr_ptr_q + 1'b1;
                last_grant_q         <= grant_idx;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule
